// File: rtl/seq_accumulator.sv
// seq_accumulator: counts a programmed number of unsigned samples into a
// WIDTH-bit running sum (wrap or saturate), with a sticky overflow flag and
// a valid/ready result handshake. Outputs depend on registered state only.
module seq_accumulator #(
  parameter int WIDTH = 8,
  parameter int CNT_W = 8
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             start,
  input  logic [CNT_W-1:0] num_samples,
  input  logic             sat_mode,
  input  logic             in_valid,
  input  logic [WIDTH-1:0] in_data,
  output logic             in_ready,
  output logic [WIDTH-1:0] sum,
  output logic             overflow,
  output logic             out_valid,
  input  logic             out_ready,
  output logic             busy
);

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] ACCUM = 2'd1;
  localparam logic [1:0] DONE  = 2'd2;

  logic [1:0]       state;
  logic [CNT_W-1:0] count;
  logic             mode;
  logic [WIDTH-1:0] sum_q;
  logic             ovf_q;
  logic [WIDTH:0]   total;
  logic             xfer;

  // Handshake and status flags are pure decodes of the current state.
  always_comb begin
    in_ready  = (state == ACCUM);
    out_valid = (state == DONE);
    busy      = (state == ACCUM) || (state == DONE);
    sum       = sum_q;
    overflow  = ovf_q;
  end

  // Carry-extended add of the current sample onto the running sum.
  always_comb begin
    total = {1'b0, sum_q} + {1'b0, in_data};
    xfer  = in_valid && (state == ACCUM);
  end

  // Run control: latch run parameters on start, accumulate on transfers,
  // hold the result until the consumer takes it.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state <= IDLE;
      count <= '0;
      mode  <= 1'b0;
      sum_q <= '0;
      ovf_q <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            sum_q <= '0;
            ovf_q <= 1'b0;
            count <= num_samples;
            mode  <= sat_mode;
            state <= (num_samples != '0) ? ACCUM : DONE;
          end
        end
        ACCUM: begin
          if (xfer) begin
            if (total[WIDTH]) begin
              ovf_q <= 1'b1;
              sum_q <= mode ? '1 : total[WIDTH-1:0];
            end else begin
              sum_q <= total[WIDTH-1:0];
            end
            count <= count - 1'b1;
            if (count == CNT_W'(1)) state <= DONE;
          end
        end
        DONE: begin
          if (out_ready) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_seq_accumulator.sv
// Bench for seq_accumulator: directed scenarios with literal expectations,
// then randomized traffic checked every cycle against a behavioural model.
module tb_seq_accumulator;

  localparam int WIDTH = 8;
  localparam int CNT_W = 8;
  localparam int MAXV  = (1 << WIDTH) - 1;

  logic             clock = 1'b0;
  logic             reset = 1'b1;
  logic             start = 1'b0;
  logic [CNT_W-1:0] num_samples = '0;
  logic             sat_mode = 1'b0;
  logic             in_valid = 1'b0;
  logic [WIDTH-1:0] in_data = '0;
  logic             in_ready;
  logic [WIDTH-1:0] sum;
  logic             overflow;
  logic             out_valid;
  logic             out_ready = 1'b0;
  logic             busy;

  int total = 0;
  int bad   = 0;

  seq_accumulator #(.WIDTH(WIDTH), .CNT_W(CNT_W)) dut (
    .clock(clock), .reset(reset), .start(start), .num_samples(num_samples),
    .sat_mode(sat_mode), .in_valid(in_valid), .in_data(in_data),
    .in_ready(in_ready), .sum(sum), .overflow(overflow),
    .out_valid(out_valid), .out_ready(out_ready), .busy(busy)
  );

  always #5 clock = ~clock;

  // Behavioural model: a run is either accumulating, holding a result, or idle.
  int m_sum = 0;
  bit m_ovf = 0;
  bit m_active = 0;
  bit m_done = 0;
  int m_left = 0;
  bit m_sat = 0;

  always @(posedge clock or posedge reset) begin
    int s;
    if (reset) begin
      m_sum = 0; m_ovf = 0; m_active = 0; m_done = 0; m_left = 0; m_sat = 0;
    end else if (m_done) begin
      if (out_ready) m_done = 0;
    end else if (m_active) begin
      if (in_valid) begin
        s = m_sum + int'(in_data);
        if (s > MAXV) begin
          m_ovf = 1;
          m_sum = m_sat ? MAXV : s - (MAXV + 1);
        end else begin
          m_sum = s;
        end
        m_left = m_left - 1;
        if (m_left == 0) begin
          m_active = 0;
          m_done   = 1;
        end
      end
    end else if (start) begin
      m_sum = 0; m_ovf = 0;
      m_left = int'(num_samples);
      m_sat  = sat_mode;
      if (m_left == 0) m_done = 1;
      else m_active = 1;
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Every-cycle comparison of all outputs against the model.
  always @(negedge clock) begin
    check("in_ready", 32'(in_ready), 32'(m_active));
    check("out_valid", 32'(out_valid), 32'(m_done));
    check("busy", 32'(busy), 32'(m_active | m_done));
    check("sum", 32'(sum), 32'(m_sum));
    check("overflow", 32'(overflow), 32'(m_ovf));
  end

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic do_start(input int n, input bit sat);
    start = 1'b1; num_samples = CNT_W'(n); sat_mode = sat;
    tick();
    start = 1'b0; num_samples = '0; sat_mode = 1'b0;
  endtask

  task automatic feed(input int v);
    in_valid = 1'b1; in_data = WIDTH'(v);
    tick();
    in_valid = 1'b0; in_data = '0;
  endtask

  task automatic release_result();
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    check("idle_after_take", 32'(busy | out_valid), 32'd0);
  endtask

  initial begin
    tick(); tick();
    check("rst_sum", 32'(sum), 32'd0);
    check("rst_ovf", 32'(overflow), 32'd0);
    check("rst_in_ready", 32'(in_ready), 32'd0);
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    reset = 1'b0;
    tick();

    // Basic run with gaps between samples, then a stalled consumer.
    do_start(4, 1'b0);
    for (int i = 1; i <= 4; i++) begin
      feed(i);
      if (i < 4) tick();
    end
    check("basic_out_valid", 32'(out_valid), 32'd1);
    check("basic_sum", 32'(sum), 32'd10);
    check("basic_ovf", 32'(overflow), 32'd0);
    for (int i = 0; i < 3; i++) begin
      tick();
      check("hold_out_valid", 32'(out_valid), 32'd1);
      check("hold_sum", 32'(sum), 32'd10);
    end
    release_result();
    check("idle_sum_kept", 32'(sum), 32'd10);

    // Wrap arithmetic.
    do_start(3, 1'b0);
    feed(200); check("wrap_s1", 32'(sum), 32'd200); check("wrap_o1", 32'(overflow), 32'd0);
    feed(100); check("wrap_s2", 32'(sum), 32'd44);  check("wrap_o2", 32'(overflow), 32'd1);
    feed(10);  check("wrap_s3", 32'(sum), 32'd54);  check("wrap_o3", 32'(overflow), 32'd1);
    check("wrap_done", 32'(out_valid), 32'd1);
    release_result();

    // Saturating arithmetic.
    do_start(3, 1'b1);
    feed(200); check("sat_s1", 32'(sum), 32'd200);
    feed(100); check("sat_s2", 32'(sum), 32'd255); check("sat_o2", 32'(overflow), 32'd1);
    feed(10);  check("sat_s3", 32'(sum), 32'd255); check("sat_o3", 32'(overflow), 32'd1);
    release_result();

    // Zero-length run.
    do_start(0, 1'b0);
    check("zero_out_valid", 32'(out_valid), 32'd1);
    check("zero_in_ready", 32'(in_ready), 32'd0);
    check("zero_sum", 32'(sum), 32'd0);
    check("zero_ovf", 32'(overflow), 32'd0);
    release_result();

    // Start pulse during an active run is ignored.
    do_start(2, 1'b0);
    start = 1'b1; num_samples = CNT_W'(9);
    tick();
    start = 1'b0; num_samples = '0;
    feed(5);
    feed(6);
    check("ign_done", 32'(out_valid), 32'd1);
    check("ign_sum", 32'(sum), 32'd11);
    release_result();

    // Asynchronous reset between clock edges mid-run.
    do_start(5, 1'b0);
    feed(7);
    feed(8);
    #3 reset = 1'b1;
    #1;
    check("areset_sum", 32'(sum), 32'd0);
    check("areset_ovf", 32'(overflow), 32'd0);
    check("areset_in_ready", 32'(in_ready), 32'd0);
    check("areset_out_valid", 32'(out_valid), 32'd0);
    tick();
    reset = 1'b0;
    tick();
    do_start(2, 1'b0);
    feed(3);
    feed(4);
    check("after_reset_sum", 32'(sum), 32'd7);
    check("after_reset_done", 32'(out_valid), 32'd1);
    release_result();

    // Randomized traffic; the per-cycle compare does the checking.
    for (int c = 0; c < 4000; c++) begin
      start       = ($urandom_range(0, 3) == 0);
      num_samples = CNT_W'($urandom_range(0, 6));
      sat_mode    = $urandom_range(0, 1) == 1;
      in_valid    = $urandom_range(0, 2) != 0;
      in_data     = WIDTH'($urandom_range(0, MAXV));
      out_ready   = $urandom_range(0, 2) == 0;
      tick();
    end
    start = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    tick();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
